// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM states, reset address default,
// instruction word size and an address alignment helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response port and decode.
// Entries are {pc, instr}; flush empties the buffer and wins over push/pop.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    output logic [63:0]   head_data,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // The fetch unit never pushes into a full buffer (it reserves a slot
    // before requesting), so push needs no full guard here.
    assign do_push   = push && !flush;
    assign do_pop    = pop && !flush && (count != '0);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Entry storage; contents are only observed while the entry is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word reads to instruction memory, buffers
// in-order responses tagged with their address, and presents them to decode.
// Redirects restart fetch at a new target and drop every response still in
// flight.
//
// Handshakes: imem_req/imem_gnt transfers a request when both are high in a
// cycle; imem_req/imem_addr stay stable until granted unless a redirect
// cancels them. instr_valid/instr_ready transfers an instruction when both
// are high; instruction/instr_pc stay stable while instr_valid && !instr_ready.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [1:0]  fsm_state
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_drain;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic [63:0]   head;
    logic          fifo_empty;
    logic          grant;
    logic          pop;
    logic          push;
    logic          room;

    assign target_pc = word_align(redirect_pc);
    assign grant     = imem_req && imem_gnt;
    assign pop       = instr_valid && instr_ready;
    // A response arriving alongside a redirect belongs to the old stream.
    assign push      = imem_rvalid && (discard == '0) && !redirect_valid;
    // Outstanding count after this cycle's response, before any new grant.
    assign out_drain = (imem_rvalid && (outstanding != '0)) ? outstanding - CW'(1) : outstanding;
    // Slots already claimed by in-flight or buffered fetches; an entry being
    // popped this cycle frees its slot so a steady stream needs no bubbles.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count} - (CW + 1)'(pop);
    assign room      = in_use < (CW + 1)'(DEPTH);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and request generation; requests are suppressed during a
    // redirect, so no grant can coincide with one.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = room && !redirect_valid;
                if (redirect_valid && (out_drain != '0)) state_next = FLUSH;
            end
            FLUSH: begin
                if (out_drain == '0) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetch address, response tagging, in-flight and discard counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_drain + CW'(grant);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                // Every request still in flight after this cycle is stale.
                discard  <= out_drain;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
                if (push)  resp_pc  <= resp_pc + 32'(WORD_BYTES);
                if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_addr   = fetch_pc;
    assign instr_valid = !fifo_empty;
    assign instruction = fifo_empty ? '0 : head[31:0];
    assign instr_pc    = fifo_empty ? '0 : head[63:32];
    assign fsm_state   = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized
// phase, with an in-order memory model and a stream-level reference model.
module tb_instruction_fetch;
    import cpu_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          DEPTH       = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .RESET_PC (TB_RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .fsm_state      (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    gnt_pct = 100;
    int    rv_pct  = 100;
    int    lat_min = 1;
    int    lat_max = 1;
    int    cyc     = 0;

    task automatic set_mem(input int g, input int r, input int lmin, input int lmax);
        gnt_pct = g;
        rv_pct  = r;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else begin
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
        @(negedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_gnt)
                mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            check("outstanding_bound", 32'(mq.size() <= DEPTH), 32'd1);
        end
    end

    // ---------------- stream reference model ----------------
    // Decode must see consecutive words from the last restart point (reset
    // or redirect); granted addresses follow the same rule.
    logic [31:0] exp_pc    = TB_RESET_PC;
    logic [31:0] exp_fetch = TB_RESET_PC;
    logic [31:0] prev_addr = '0;
    bit          prev_wait = 1'b0;
    bit          chk_quiet = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc    = TB_RESET_PC;
            exp_fetch = TB_RESET_PC;
            prev_wait = 1'b0;
            chk_quiet = 1'b0;
        end else begin
            if (chk_quiet) check("quiet_after_redirect", 32'(instr_valid), 32'd0);
            if (prev_wait && !redirect_valid) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (redirect_valid) check("no_req_on_redirect", 32'(imem_req), 32'd0);
            if (imem_req && imem_gnt) begin
                check("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (instr_valid && instr_ready) begin
                check("instr_pc", instr_pc, exp_pc);
                check("instruction", instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            prev_wait = imem_req && !imem_gnt && !redirect_valid;
            prev_addr = imem_addr;
            chk_quiet = redirect_valid;
            if (redirect_valid) begin
                exp_pc    = redirect_pc & 32'hFFFF_FFFC;
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic restart(input logic rdy);
        @(posedge clk);
        #1;
        reset          = 1'b1;
        instr_ready    = rdy;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          v_tab[5];
        logic [31:0] pc_tab[5];
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        int          grants;
        bit          found;
        bit          any_valid;

        v_tab  = '{0, 0, 1, 1, 1};
        pc_tab = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        check("rst_instruction", instruction, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));

        // Reset release, 1-cycle memory, decode always ready
        set_mem(100, 100, 1, 1);
        restart(1'b1);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_req", 32'(imem_req), 32'd1);
                check("first_addr", imem_addr, TB_RESET_PC);
            end
            check("startup_valid", 32'(instr_valid), 32'(v_tab[k-1]));
            if (v_tab[k-1] == 1) check("startup_pc", instr_pc, pc_tab[k-1]);
        end

        // Decode stalled: only DEPTH fetches may be taken, nothing lost
        restart(1'b0);
        grants = 0;
        repeat (12) begin
            @(negedge clk);
            if (imem_req && imem_gnt) grants++;
        end
        check("stall_grants", 32'(grants), 32'(DEPTH));
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        got_q.delete();
        for (int i = 0; i < 20 && got_q.size() < 4; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) got_q.push_back(instr_pc);
        end
        check("stall_release_count", 32'(got_q.size()), 32'd4);
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("stall_release_pc", got_q.pop_front(), exp_q.pop_front());

        // Redirect with two requests in flight
        set_mem(100, 100, 3, 3);
        restart(1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mq.size() == 2) found = 1'b1;
        end
        check("two_in_flight", 32'(found), 32'd1);
        pulse_redirect(32'h0000_1003);
        @(negedge clk);
        check("flush_state", 32'(fsm_state), 32'(FLUSH));
        found     = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) any_valid = 1'b1;
            if (imem_req) found = 1'b1;
            else @(negedge clk);
        end
        check("flush_req_seen", 32'(found), 32'd1);
        check("flush_no_valid", 32'(any_valid), 32'd0);
        check("flush_next_addr", imem_addr, 32'h0000_1000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        check("flush_valid_seen", 32'(found), 32'd1);
        check("flush_next_pc", instr_pc, 32'h0000_1000);
        check("flush_next_instr", instruction, mem_word(32'h0000_1000));

        // Redirect coinciding with a decode handshake and a memory response
        set_mem(100, 100, 1, 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        @(negedge clk);
        check("coinc_handshake", 32'(instr_valid && instr_ready), 32'd1);
        check("coinc_rvalid", 32'(imem_rvalid), 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        check("coinc_valid_seen", 32'(found), 32'd1);
        check("coinc_next_pc", instr_pc, 32'h0000_2000);

        // Address wrap at the top of memory
        pulse_redirect(32'hFFFF_FFF8);
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        got_q.delete();
        for (int i = 0; i < 20 && got_q.size() < 3; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) got_q.push_back(imem_addr);
        end
        check("wrap_count", 32'(got_q.size()), 32'd3);
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("wrap_addr", got_q.pop_front(), exp_q.pop_front());

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0)
                set_mem($urandom_range(100, 20), $urandom_range(100, 20), 1, $urandom_range(4, 1));
            @(posedge clk);
            #1;
            instr_ready    = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc    = $urandom;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;

        // Asynchronous reset with a full buffer
        set_mem(100, 100, 1, 2);
        instr_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mq.size() == 0 && instr_valid && !imem_req) found = 1'b1;
        end
        check("full_before_reset", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_instr_valid", 32'(instr_valid), 32'd0);
        check("async_imem_req", 32'(imem_req), 32'd0);
        check("async_imem_addr", imem_addr, TB_RESET_PC);
        check("async_instruction", instruction, 32'd0);
        check("async_instr_pc", instr_pc, 32'd0);
        check("async_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) found = 1'b1;
        end
        check("restart_grant_seen", 32'(found), 32'd1);
        check("restart_addr", imem_addr, TB_RESET_PC);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        check("restart_valid_seen", 32'(found), 32'd1);
        check("restart_pc", instr_pc, TB_RESET_PC);

        repeat (10) @(negedge clk);

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
